// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Provides the controller state encoding, the word size and helper functions
// that derive the offset/index/tag field widths from the cache geometry.
package icache_pkg;

    // Controller states: lookup, sequential line refill, and line commit.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;

    // Word-select bits within a line.
    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-select bits.
    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Whatever remains above byte, word and line select is the tag.
    function automatic int tag_bits(input int bit_count, input int line_words,
                                    input int num_lines);
        return bit_count - $clog2(WORD_BYTES) - offset_bits(line_words)
               - index_bits(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage for the direct-mapped instruction cache.
// Holds one valid bit, one tag and LINE_WORDS 32-bit words per line in flops.
// Reads are asynchronous; one write index serves both the per-word data
// write (during refill) and the tag/valid commit (at end of refill).
// Ports:
//   clk, reset      clock; synchronous active-high reset clears valid bits only
//   rd_index/offset lookup address; rd_valid/rd_tag/rd_word combinational
//   wr_index        line being refilled
//   wr_word_en      write wr_data into word wr_offset of line wr_index
//   tag_wr_en       write tag_wr_tag and tag_wr_valid into line wr_index
//   clr_all         invalidate every line at this edge
module icache_line_array
    import icache_pkg::*;
#(
    parameter int  BIT_COUNT   = 32,
    parameter int  LINE_WORDS  = 4,
    parameter int  NUM_LINES   = 16,
    localparam int OFFSET_BITS = offset_bits(LINE_WORDS),
    localparam int INDEX_BITS  = index_bits(NUM_LINES),
    localparam int TAG_BITS    = tag_bits(BIT_COUNT, LINE_WORDS, NUM_LINES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [31:0]            rd_word,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic                   wr_word_en,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [31:0]            wr_data,
    input  logic                   tag_wr_en,
    input  logic [TAG_BITS-1:0]    tag_wr_tag,
    input  logic                   tag_wr_valid,
    input  logic                   clr_all
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [TAG_BITS-1:0]  tag_d  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
    logic [31:0]          data_d [NUM_LINES][LINE_WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[rd_index][rd_offset];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        // Bulk clear first so a same-cycle commit still decides its own line;
        // the controller folds any concurrent flush into tag_wr_valid.
        if (clr_all) begin
            valid_d = '0;
        end
        if (tag_wr_en) begin
            valid_d[wr_index] = tag_wr_valid;
            tag_d[wr_index]   = tag_wr_tag;
        end
        if (wr_word_en) begin
            data_d[wr_index][wr_offset] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags and data are meaningless while their valid bit is clear.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/direct_mapped_icache.sv
// Direct-mapped instruction cache between the core fetch port and a
// multi-cycle backing instruction memory.
// A hit returns the instruction combinationally in the same cycle. A miss
// stalls the core, refills the whole line one word at a time starting at
// word 0, commits the tag, and the fetch hits on the cycle after returning
// to IDLE. Flush (fence.i) invalidates every line.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   FetchEn, PC          fetch request and byte address (PC[1:0] ignored)
//   Flush                invalidate all lines
//   Instr, InstrValid    instruction word and its qualifier
//   Stall                FetchEn & ~InstrValid; core holds PC while high
//   MemReq, MemAdr       word read request and word-aligned address
//   MemReadData/Valid    returned word; only consumed while MemReq=1
//   HitCount, MissCount  free-running 32-bit event counters
module direct_mapped_icache
    import icache_pkg::*;
#(
    parameter int BIT_COUNT  = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 FetchEn,
    input  logic [BIT_COUNT-1:0] PC,
    input  logic                 Flush,
    output logic [31:0]          Instr,
    output logic                 InstrValid,
    output logic                 Stall,
    output logic                 MemReq,
    output logic [BIT_COUNT-1:0] MemAdr,
    input  logic [31:0]          MemReadData,
    input  logic                 MemReadValid,
    output logic [31:0]          HitCount,
    output logic [31:0]          MissCount
);

    localparam int OFFSET_BITS = offset_bits(LINE_WORDS);
    localparam int INDEX_BITS  = index_bits(NUM_LINES);
    localparam int TAG_BITS    = tag_bits(BIT_COUNT, LINE_WORDS, NUM_LINES);
    localparam int OFF_LSB     = $clog2(WORD_BYTES);
    localparam int IDX_LSB     = OFF_LSB + OFFSET_BITS;
    localparam int TAG_LSB     = IDX_LSB + INDEX_BITS;

    localparam logic [BIT_COUNT-1:0]   LINE_MASK =
        {{(BIT_COUNT-IDX_LSB){1'b1}}, {IDX_LSB{1'b0}}};
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(LINE_WORDS - 1);

    // Address fields of the current fetch.
    logic [OFFSET_BITS-1:0] pc_offset;
    logic [INDEX_BITS-1:0]  pc_index;
    logic [TAG_BITS-1:0]    pc_tag;
    logic                   unused_pc_bits;

    assign pc_offset      = PC[OFF_LSB +: OFFSET_BITS];
    assign pc_index       = PC[IDX_LSB +: INDEX_BITS];
    assign pc_tag         = PC[BIT_COUNT-1:TAG_LSB];
    assign unused_pc_bits = ^PC[OFF_LSB-1:0];

    // Controller state.
    state_e                 state_q, state_d;
    logic [BIT_COUNT-1:0]   base_q, base_d;
    logic [INDEX_BITS-1:0]  index_q, index_d;
    logic [TAG_BITS-1:0]    line_tag_q, line_tag_d;
    logic [OFFSET_BITS-1:0] word_cnt_q, word_cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic [BIT_COUNT-1:0]   mem_adr_q, mem_adr_d;
    logic [31:0]            hit_count_q, hit_count_d;
    logic [31:0]            miss_count_q, miss_count_d;
    logic                   flush_pending_q, flush_pending_d;

    // Line array interface.
    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [31:0]            rd_word;
    logic                   wr_word_en;
    logic                   tag_wr_en;
    logic                   tag_wr_valid;

    logic                   lookup_hit;
    logic                   hit;
    logic [OFFSET_BITS-1:0] word_cnt_inc;
    logic [BIT_COUNT-1:0]   word_byte_off;

    icache_line_array #(
        .BIT_COUNT (BIT_COUNT),
        .LINE_WORDS(LINE_WORDS),
        .NUM_LINES (NUM_LINES)
    ) u_lines (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (pc_index),
        .rd_offset   (pc_offset),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_word     (rd_word),
        .wr_index    (index_q),
        .wr_word_en  (wr_word_en),
        .wr_offset   (word_cnt_q),
        .wr_data     (MemReadData),
        .tag_wr_en   (tag_wr_en),
        .tag_wr_tag  (line_tag_q),
        .tag_wr_valid(tag_wr_valid),
        .clr_all     (Flush)
    );

    // A flush cycle never delivers an instruction, even if the line is
    // still valid before the edge that clears it.
    assign lookup_hit = rd_valid & (rd_tag == pc_tag);
    assign hit        = lookup_hit & ~Flush;

    assign Instr      = rd_word;
    assign InstrValid = FetchEn & hit & (state_q == IDLE);
    assign Stall      = FetchEn & ~InstrValid;
    assign MemReq     = mem_req_q;
    assign MemAdr     = mem_adr_q;
    assign HitCount   = hit_count_q;
    assign MissCount  = miss_count_q;

    // Byte offset of the next word in the line; the line base has these
    // bits zeroed, so OR-ing it in is the same as adding.
    always_comb begin
        word_cnt_inc  = word_cnt_q + OFFSET_BITS'(1);
        word_byte_off = '0;
        word_byte_off[OFF_LSB +: OFFSET_BITS] = word_cnt_inc;
    end

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        index_d         = index_q;
        line_tag_d      = line_tag_q;
        word_cnt_d      = word_cnt_q;
        mem_req_d       = mem_req_q;
        mem_adr_d       = mem_adr_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        flush_pending_d = flush_pending_q;
        wr_word_en      = 1'b0;
        tag_wr_en       = 1'b0;
        tag_wr_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Flush) begin
                    // Lines are cleared this edge; any miss is taken next cycle.
                end else if (FetchEn && !lookup_hit) begin
                    base_d       = PC & LINE_MASK;
                    index_d      = pc_index;
                    line_tag_d   = pc_tag;
                    word_cnt_d   = '0;
                    mem_req_d    = 1'b1;
                    mem_adr_d    = PC & LINE_MASK;
                    miss_count_d = miss_count_q + 32'd1;
                    state_d      = REFILL;
                end else if (FetchEn) begin
                    hit_count_d  = hit_count_q + 32'd1;
                end
            end

            REFILL: begin
                if (Flush) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_req_q && MemReadValid) begin
                    wr_word_en = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        mem_req_d = 1'b0;
                        state_d   = FILL_DONE;
                    end else begin
                        word_cnt_d = word_cnt_inc;
                        mem_adr_d  = base_q | word_byte_off;
                    end
                end
            end

            FILL_DONE: begin
                // A flush seen during the refill, or arriving right now,
                // leaves the freshly written line invalid.
                tag_wr_en       = 1'b1;
                tag_wr_valid    = ~(flush_pending_q | Flush);
                flush_pending_d = 1'b0;
                mem_req_d       = 1'b0;
                state_d         = IDLE;
            end

            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            word_cnt_q      <= '0;
            mem_req_q       <= 1'b0;
            mem_adr_q       <= '0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_cnt_q      <= word_cnt_d;
            mem_req_q       <= mem_req_d;
            mem_adr_q       <= mem_adr_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Latched line address; only meaningful while a refill is in flight.
    always_ff @(posedge clk) begin
        base_q     <= base_d;
        index_q    <= index_d;
        line_tag_q <= line_tag_d;
    end

endmodule

// File: doc/direct_mapped_icache.md
Name: direct_mapped_icache

Overview:
- Parametrised direct-mapped instruction cache between the compute core's fetch port (PC/Instr) and a multi-cycle backing instruction memory.
- Successor to the zero-latency fetch path: adds line buffering, miss detection, a stall handshake toward the core, sequential line refill, whole-cache flush (fence.i) and hit/miss counters.
- Sits in the cached core top level in place of the direct instruction-memory connection.

Parameters:
- BIT_COUNT, 32, address width (32 or 64); Instr is always 32 bits.
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.
- NUM_LINES, 16, number of lines; power of two, 2..256.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- FetchEn  input  1  core requests an instruction this cycle.
- PC  input  BIT_COUNT  fetch byte address; bits [1:0] ignored.
- Flush  input  1  invalidate all lines (fence.i).
- Instr  output  32  instruction word; valid only when InstrValid=1.
- InstrValid  output  1  FetchEn & hit & state==IDLE (combinational).
- Stall  output  1  FetchEn & ~InstrValid; core holds PC while high.
- MemReq  output  1  backing-memory word read request.
- MemAdr  output  BIT_COUNT  word-aligned request address; stable while MemReq=1.
- MemReadData  input  32  returned word.
- MemReadValid  input  1  MemReadData valid; consumed only when MemReq=1.
- HitCount  output  32  hit counter.
- MissCount  output  32  miss counter.

Behaviour:
- Address split: offset = PC[2 +: log2(LINE_WORDS)], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Storage: valid bit, tag, and LINE_WORDS data words per line; flop-based, asynchronous read.
- Hit = valid[index] & (tag[index] == PC tag); Instr = data[index][offset], combinational, same cycle.
- Reset: state=IDLE, all valid=0, MemReq=0, MemAdr=0, HitCount=0, MissCount=0, FlushPending=0. Instr/Instr data contents are don't-care. Stall and InstrValid follow their combinational definitions.
- FSM:
  - IDLE: if FetchEn & ~hit & ~Flush: latch line base (PC with offset and [1:0] zeroed), index and tag; WordCnt=0; MissCount+=1; go to REFILL. If FetchEn & hit: HitCount+=1, stay.
  - REFILL: MemReq=1, MemAdr = base + 4*WordCnt. On MemReadValid: write data[index][WordCnt]. If WordCnt == LINE_WORDS-1, go to FILL_DONE; else WordCnt+=1 and MemReq stays high with the new address the next cycle.
  - FILL_DONE: tag[index] = latched tag; valid[index] = ~FlushPending; clear FlushPending; MemReq=0; go to IDLE.
- Refill miss latency: a miss fetch hits on the cycle after return to IDLE. Total = 1 + sum(word latencies) + 1 cycles.
- PC changes during REFILL are ignored. The latched line completes; lookup resumes with the current PC in IDLE.
- Flush in IDLE: all valid=0 at the edge; no hit is counted that cycle. Stall=1 that cycle if FetchEn; the miss is taken the next cycle.
- Flush in REFILL or FILL_DONE: set FlushPending; clear all valid bits immediately. The refilled line is written but left invalid.
- MemReadValid while MemReq=0 is ignored; no state change.
- Counters wrap modulo 2^32. Simultaneous hit and Flush: flush wins, no count.
- reset asserted mid-refill: IDLE, MemReq=0 at that edge, all lines invalid; late memory responses are ignored.

Decomposition:
- Shared package icache_pkg: state enum (IDLE, REFILL, FILL_DONE); localparam functions for OFFSET_BITS, INDEX_BITS, TAG_BITS from BIT_COUNT/LINE_WORDS/NUM_LINES; WORD_BYTES=4.
- One sub-module: icache_line_array (valid/tag/data storage, async read, single write port, bulk valid clear).

Test Plan (BIT_COUNT=32, LINE_WORDS=4, NUM_LINES=16, memory model returns word = address XOR 0xA5A5_0000 with 2-cycle latency per word):
- Cold miss: reset, FetchEn=1, PC=0x100 -> Stall=1 for 10 cycles; MemAdr sequence 0x100,0x104,0x108,0x10C; then Instr=0xA5A5_0100, InstrValid=1; MissCount=1.
- Sequential hits: after the fill, PC=0x104,0x108,0x10C on consecutive cycles -> InstrValid=1 each cycle, Instr=0xA5A5_0104/0108/010C; HitCount=4.
- Conflict eviction: fill 0x100, then fetch 0x200 (same index 0, different tag) -> miss and refill; refetch 0x100 -> miss again; MissCount=3.
- Flush mid-refill: miss on 0x300, assert Flush during the 2nd word -> refill completes; fetch 0x300 -> miss again; the earlier 0x100 line also misses.
- Reset mid-refill: assert reset during the 3rd word at 0x400 -> MemReq=0 next cycle; a stray MemReadValid is ignored; fetch 0x400 -> full refill from word 0.
- PC change during refill: miss on 0x500, PC switched to 0x600 during REFILL -> line 0x500 becomes valid; 0x600 then misses and refills; MissCount=2.
